// File: rtl/acc_core_pkg.sv
// Shared opcode values, state encoding and small decode helpers for the
// accumulator core family.
package acc_core_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OP_W-1:0] OP_HALT  = 4'h1;
    localparam logic [OP_W-1:0] OP_LDI   = 4'h2;
    localparam logic [OP_W-1:0] OP_LDM   = 4'h3;
    localparam logic [OP_W-1:0] OP_STM   = 4'h4;
    localparam logic [OP_W-1:0] OP_MVAR  = 4'h5;
    localparam logic [OP_W-1:0] OP_MVRG  = 4'h6;
    localparam logic [OP_W-1:0] OP_MVGA  = 4'h7;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h8;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h9;
    localparam logic [OP_W-1:0] OP_MUL   = 4'hA;
    localparam logic [OP_W-1:0] OP_INC   = 4'hB;
    localparam logic [OP_W-1:0] OP_JMP   = 4'hC;
    localparam logic [OP_W-1:0] OP_JZ    = 4'hD;
    localparam logic [OP_W-1:0] OP_LDCID = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD_IR = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_MEM_RD  = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    // Only the arithmetic group (ADD..INC) updates the zero flag.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_INC);
    endfunction

endpackage

// File: rtl/acc_core_regfile.sv
// General-purpose register file: one synchronous write port, one
// combinational read port, all entries cleared by reset.
module acc_core_regfile #(
    parameter int DATA_W  = 16,
    parameter int NUM_GPR = 4,
    parameter int IDX_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs_r [NUM_GPR];

    // Register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata = regs_r[raddr];

endmodule

// File: rtl/acc_core_v2.sv
// Multi-cycle accumulator core with a req/gnt/rvalid data-memory port so
// several cores can share one data memory behind an arbiter.
module acc_core_v2
    import acc_core_pkg::*;
#(
    parameter int CID     = 0,
    parameter int DATA_W  = 16,
    parameter int NUM_GPR = 4,
    parameter int PC_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [PC_W-1:0]   im_addr,
    output logic              im_en,
    input  logic [DATA_W-1:0] im_rdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              done
);

    localparam int IDX_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

    state_t              state_r, next_state_s;
    logic [PC_W-1:0]     pc_r;
    logic [DATA_W-1:0]   ir_r, ac_r, ar_r;
    logic                z_r;
    logic                im_en_r, dm_req_r, dm_we_r, done_r;

    logic [OP_W-1:0]     op_s;
    logic [DATA_W-1:0]   imm_s, alu_s, gpr_rdata_s;
    logic [IDX_W-1:0]    gpr_idx_s;
    logic [PC_W-1:0]     jump_tgt_s;
    logic                gpr_we_s;

    assign op_s       = ir_r[DATA_W-1 -: OP_W];
    assign imm_s      = DATA_W'(ir_r[DATA_W-OP_W-1:0]);
    assign gpr_idx_s  = IDX_W'({1'b0, ir_r[2:0]} % 4'(NUM_GPR));
    assign jump_tgt_s = PC_W'(imm_s);
    assign gpr_we_s   = (state_r == ST_EXEC) && (op_s == OP_MVRG);

    acc_core_regfile #(
        .DATA_W  (DATA_W),
        .NUM_GPR (NUM_GPR),
        .IDX_W   (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (gpr_we_s),
        .waddr (gpr_idx_s),
        .wdata (ac_r),
        .raddr (gpr_idx_s),
        .rdata (gpr_rdata_s)
    );

    // Arithmetic unit; results wrap modulo 2^DATA_W.
    always_comb begin
        alu_s = ac_r;
        case (op_s)
            OP_ADD:  alu_s = ac_r + gpr_rdata_s;
            OP_SUB:  alu_s = ac_r - gpr_rdata_s;
            OP_MUL:  alu_s = ac_r * gpr_rdata_s;
            OP_INC:  alu_s = ac_r + DATA_W'(1);
            default: alu_s = ac_r;
        endcase
    end

    // Next-state logic; the memory states wait indefinitely on the arbiter.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) next_state_s = ST_FETCH;
                else       next_state_s = state_r;
            end
            ST_FETCH:   next_state_s = ST_LOAD_IR;
            ST_LOAD_IR: next_state_s = ST_EXEC;
            ST_EXEC: begin
                case (op_s)
                    OP_HALT:        next_state_s = ST_HALT;
                    OP_LDM, OP_STM: next_state_s = ST_MEM;
                    default:        next_state_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dm_gnt) begin
                    if (op_s == OP_STM) next_state_s = ST_FETCH;
                    else                next_state_s = ST_MEM_RD;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_MEM_RD: begin
                if (dm_rvalid) next_state_s = ST_FETCH;
                else           next_state_s = ST_MEM_RD;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register; strobes are registered from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            im_en_r  <= 1'b0;
            dm_req_r <= 1'b0;
            dm_we_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            im_en_r  <= (next_state_s == ST_FETCH);
            dm_req_r <= (next_state_s == ST_MEM);
            dm_we_r  <= (next_state_s == ST_MEM) && (op_s == OP_STM);
            done_r   <= (next_state_s == ST_HALT);
        end
    end

    // Architectural registers; a taken jump overwrites the earlier PC increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= '0;
            ir_r <= '0;
            ac_r <= '0;
            ar_r <= '0;
            z_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (start) pc_r <= '0;
                end
                ST_LOAD_IR: begin
                    ir_r <= im_rdata;
                    pc_r <= pc_r + PC_W'(1);
                end
                ST_EXEC: begin
                    case (op_s)
                        OP_LDI:   ac_r <= imm_s;
                        OP_MVAR:  ar_r <= ac_r;
                        OP_MVGA:  ac_r <= gpr_rdata_s;
                        OP_JMP:   pc_r <= jump_tgt_s;
                        OP_JZ:    if (z_r) pc_r <= jump_tgt_s;
                        OP_LDCID: ac_r <= DATA_W'(CID);
                        default: begin
                            if (is_alu_op(op_s)) begin
                                ac_r <= alu_s;
                                z_r  <= (alu_s == '0);
                            end
                        end
                    endcase
                end
                ST_MEM_RD: begin
                    if (dm_rvalid) ac_r <= dm_rdata;
                end
                default: ;
            endcase
        end
    end

    assign im_addr  = pc_r;
    assign im_en    = im_en_r;
    assign dm_req   = dm_req_r;
    assign dm_we    = dm_we_r;
    assign dm_addr  = ar_r;
    assign dm_wdata = ac_r;
    assign done     = done_r;

endmodule
